// File: rtl/score_uart_pkg.sv
// Shared state encoding, ASCII constants and frame sizing helpers
// for the score UART reporter.
package score_uart_pkg;

  typedef enum logic [1:0] {StIdle, StConvert, StSend, StWait} state_e;

  localparam logic [7:0] CH_S    = 8'h53;
  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;

  // 'S' + digits + CR + LF
  function automatic int unsigned frame_len(input int unsigned num_digits);
    return num_digits + 3;
  endfunction

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one bit per clock, done pulses exactly
// SCORE_W cycles after start with the BCD result stable on bcd.
module bin2bcd_serial #(
  parameter int unsigned SCORE_W    = 20,
  parameter int unsigned NUM_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [SCORE_W-1:0]      bin,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int unsigned CntW = $clog2(SCORE_W + 1);
  localparam int unsigned BcdW = 4 * NUM_DIGITS;

  logic [SCORE_W-1:0] shift_q;
  logic [BcdW-1:0]    bcd_q;
  logic [BcdW-1:0]    bcd_adj;
  logic [CntW-1:0]    cnt_q;
  logic               run_q;
  logic               done_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        // The first shift is folded into the load (nothing to adjust yet),
        // so the last shift lands exactly SCORE_W cycles after start.
        bcd_q   <= BcdW'(bin[SCORE_W-1]);
        shift_q <= bin << 1;
        cnt_q   <= CntW'(1);
        run_q   <= 1'b1;
      end else if (run_q) begin
        bcd_q   <= (bcd_adj << 1) | BcdW'(shift_q[SCORE_W-1]);
        shift_q <= shift_q << 1;
        cnt_q   <= cnt_q + CntW'(1);
        if (cnt_q == CntW'(SCORE_W - 1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/score_uart_reporter.sv
// Formats the player score as "S<digits>\r\n" and feeds it byte-by-byte to
// the UART byte transmitter over its dv/active/done handshake.
module score_uart_reporter
  import score_uart_pkg::*;
#(
  parameter int unsigned SCORE_W    = 20,
  parameter int unsigned NUM_DIGITS = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] score,
  input  logic               force_send,
  input  logic               tx_active,
  input  logic               tx_done,
  output logic               tx_dv,
  output logic [7:0]         tx_byte,
  output logic               busy,
  output logic               frame_done
);

  localparam int unsigned     FRAME_LEN = frame_len(NUM_DIGITS);
  localparam int unsigned     IdxW      = $clog2(FRAME_LEN + 1);
  localparam longint unsigned SatLimit  = pow10(NUM_DIGITS);

  state_e               state_q, state_d;
  logic [SCORE_W-1:0]   last_sent_q, last_sent_d;
  logic                 pending_q, pending_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 tx_dv_q, tx_dv_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;

  logic                    conv_start;
  logic                    conv_done;
  logic [SCORE_W-1:0]      score_sat;
  logic [4*NUM_DIGITS-1:0] bcd;
  logic [3:0]              digit;
  logic [7:0]              frame_byte;

  // Scores that don't fit in NUM_DIGITS are shown as all nines.
  assign score_sat = (64'(score) >= SatLimit) ? SCORE_W'(SatLimit - 1) : score;

  bin2bcd_serial #(
    .SCORE_W    (SCORE_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (score_sat),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_comb begin
    digit = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (idx_q == IdxW'(NUM_DIGITS - d)) digit = bcd[4*d +: 4];
    end
    if (idx_q == '0)                           frame_byte = CH_S;
    else if (idx_q <= IdxW'(NUM_DIGITS))       frame_byte = CH_ZERO + {4'b0, digit};
    else if (idx_q == IdxW'(NUM_DIGITS + 1))   frame_byte = CH_CR;
    else                                       frame_byte = CH_LF;
  end

  always_comb begin
    state_d      = state_q;
    last_sent_d  = last_sent_q;
    pending_d    = pending_q;
    idx_d        = idx_q;
    tx_dv_d      = 1'b0;
    tx_byte_d    = tx_byte_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    conv_start   = 1'b0;

    if (force_send && state_q != StIdle) pending_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (score != last_sent_q || force_send || pending_q) begin
          conv_start  = 1'b1;
          last_sent_d = score;
          pending_d   = 1'b0;
          busy_d      = 1'b1;
          idx_d       = '0;
          state_d     = StConvert;
        end
      end
      StConvert: begin
        if (conv_done) state_d = StSend;
      end
      StSend: begin
        if (!tx_active) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = frame_byte;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (tx_done) begin
          if (idx_q == IdxW'(FRAME_LEN - 1)) begin
            idx_d        = '0;
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = StIdle;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StSend;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      last_sent_q  <= '0;
      pending_q    <= 1'b0;
      idx_q        <= '0;
      tx_dv_q      <= 1'b0;
      tx_byte_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_sent_q  <= last_sent_d;
      pending_q    <= pending_d;
      idx_q        <= idx_d;
      tx_dv_q      <= tx_dv_d;
      tx_byte_q    <= tx_byte_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_dv      = tx_dv_q;
  assign tx_byte    = tx_byte_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_score_uart_reporter.sv
// Scoreboard bench: stimulus queues the expected frame text, a monitor pops
// and compares each byte the reporter hands to a modelled transmitter.
module tb_score_uart_reporter;

  localparam int unsigned SCORE_W    = 20;
  localparam int unsigned NUM_DIGITS = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic [SCORE_W-1:0] score;
  logic               force_send;
  logic               tx_active;
  logic               tx_done;
  logic               tx_dv;
  logic [7:0]         tx_byte;
  logic               busy;
  logic               frame_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int dv_count = 0;
  int frames_seen = 0;
  int frames_exp = 0;
  int in_frame = 0;
  int tx_len_cfg = 10;
  logic [7:0] exp_q[$];

  score_uart_reporter #(
    .SCORE_W    (SCORE_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .score      (score),
    .force_send (force_send),
    .tx_active  (tx_active),
    .tx_done    (tx_done),
    .tx_dv      (tx_dv),
    .tx_byte    (tx_byte),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  // Reference: the frame is simply the clamped score printed as text.
  task automatic push_frame(input int unsigned val);
    string s;
    int unsigned sat;
    sat = (val > 99999) ? 99999 : val;
    s = $sformatf("S%05d", sat);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    frames_exp++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_force();
    force_send = 1'b1;
    @(negedge clk);
    force_send = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (frames_seen < n && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check("frames_done", frames_seen, n);
  endtask

  task automatic wait_dv(input int n);
    int k = 0;
    while (dv_count < n && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("dv_reached", dv_count >= n, 1);
  endtask

  // Transmitter model: busy for tx_len cycles per byte, then a done pulse.
  initial begin
    int len;
    tx_active = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_dv) begin
        len = (tx_len_cfg != 0) ? tx_len_cfg : int'($urandom_range(1, 12));
        tx_active = 1'b1;
        repeat (len) @(negedge clk);
        tx_active = 1'b0;
        tx_done   = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  // Monitor
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        in_frame = 0;
      end else begin
        if (tx_dv) begin
          dv_count++;
          in_frame++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_tx_dv: got byte %0h, wanted no transmission", tx_byte);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", tx_byte, e);
          end
        end
        if (frame_done) begin
          frames_seen++;
          check("frame_byte_count", in_frame, 8);
          check("busy_low_after_frame", busy, 0);
          in_frame = 0;
        end
      end
    end
  end

  initial begin
    int t0;
    int k;
    int base;
    int unsigned cur;
    int unsigned v;

    rst        = 1'b0;
    score      = '0;
    force_send = 1'b0;
    tick(3);
    check("rst_tx_dv", tx_dv, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    rst = 1'b1;

    // Idle with score 0: nothing to send until forced.
    tick(1000);
    check("idle_no_dv", dv_count, 0);
    push_frame(0);
    pulse_force();
    check("busy_after_trigger", busy, 1);
    wait_frames(frames_exp);

    // Latency from trigger edge to first tx_dv.
    tick(5);
    score = 12345;
    cur = 12345;
    push_frame(12345);
    t0 = cyc + 1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!tx_dv && k < 200);
    check("first_dv_latency", cyc - t0, SCORE_W + 1);
    wait_frames(frames_exp);

    // Saturation
    tick(5);
    score = 20'hFFFFF;
    cur = 20'hFFFFF;
    push_frame(cur);
    wait_frames(frames_exp);

    // Score change mid-frame produces exactly one follow-up frame.
    tick(5);
    base = dv_count;
    score = 200;
    push_frame(200);
    wait_dv(base + 3);
    score = 1200;
    cur = 1200;
    push_frame(1200);
    wait_frames(frames_exp);
    tick(300);
    check("no_third_frame", frames_seen, frames_exp);

    // Several forces while busy collapse into one extra frame.
    base = dv_count;
    push_frame(1200);
    pulse_force();
    wait_dv(base + 2);
    for (int i = 0; i < 3; i++) begin
      pulse_force();
      tick(2);
    end
    push_frame(1200);
    wait_frames(frames_exp);
    tick(300);
    check("one_extra_frame", frames_seen, frames_exp);

    // Randomized scores, variable transmitter speed, some with a coincident force.
    tx_len_cfg = 0;
    for (int i = 0; i < 8; i++) begin
      v = $urandom_range(0, 20'hFFFFF);
      if (i % 3 == 1) v = $urandom_range(0, 99999);
      if (v == cur) v = v ^ 1;
      cur = v;
      push_frame(v);
      score = SCORE_W'(v);
      if (i % 3 == 0) begin
        force_send = 1'b1;
        tick(1);
        force_send = 1'b0;
      end
      wait_frames(frames_exp);
      tick($urandom_range(1, 20));
    end
    tick(100);
    check("random_frame_count", frames_seen, frames_exp);

    // Reset during the fourth byte aborts the frame.
    tx_len_cfg = 10;
    v = (cur == 4321) ? 4322 : 4321;
    base = dv_count;
    push_frame(v);
    score = SCORE_W'(v);
    wait_dv(base + 4);
    tick(2);
    rst = 1'b0;
    #1;
    check("midrst_tx_dv", tx_dv, 0);
    check("midrst_tx_byte", tx_byte, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frame_done", frame_done, 0);
    exp_q.delete();
    frames_exp--;
    score = 0;
    tick(5);
    rst = 1'b1;
    base = dv_count;
    tick(300);
    check("no_dv_after_reset", dv_count, base);
    push_frame(777);
    score = 777;
    wait_frames(frames_exp);
    tick(50);

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
